serial_word_feeder: RTL and testbench

Parallel-in/serial-out feeder sitting directly upstream of the Moore sequence detector. Accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial line, which drives the detector's `din`. Supports MSB- or LSB-first order and a configurable idle gap between words, so known bit patterns can be streamed into the detector deterministically.

---
 rtl/feeder_pkg.sv | 17 +
 rtl/serial_word_feeder_if.sv | 23 ++
 rtl/bit_down_counter.sv | 31 +++
 rtl/serial_word_feeder.sv | 122 ++++++++++++
 tb/tb_serial_word_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/feeder_pkg.sv
// Shared definitions for the serial word feeder: state encoding and counter width.
package feeder_pkg;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_GAP   = 2'b10;

    // Wide enough for a bit count of up to 31 and a gap count of up to 14.
    localparam int CNT_W = $clog2(32);

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_GAP   = S_GAP
    } state_t;

endpackage

// File: rtl/serial_word_feeder_if.sv
// Load handshake plus serial output bundle of the feeder.
// The master modport is the word source / observer; the slave modport is the feeder.
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_valid, word_done, busy
    );
endinterface

// File: rtl/bit_down_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement, and it
// holds at zero rather than wrapping.
module bit_down_counter
    import feeder_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    // Count register: clear on reset, load, or step down towards zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-in/serial-out feeder: accepts words on a valid/ready handshake and
// shifts them out one bit per clock, with an optional idle gap between words.
module serial_word_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_word_feeder_if.slave  bus
);

    localparam bit              HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(HAS_GAP ? (GAP_CYCLES - 1) : 0);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] shifted;
    logic             head_bit;
    logic             bit_zero;
    logic             gap_zero;
    logic             in_shift;
    logic             in_gap;
    logic             last_bit;
    logic             ready;
    logic             accept;

    assign in_shift = (state_reg == ST_SHIFT);
    assign in_gap   = (state_reg == ST_GAP);
    assign last_bit = in_shift && bit_zero;

    // Ready depends on state only; without a gap the last-bit cycle can take
    // the next word so words stream back to back.
    assign ready  = (state_reg == ST_IDLE) || (last_bit && !HAS_GAP);
    assign accept = bus.load_valid && ready;

    // Bit order: pick the head bit and the shift direction once at elaboration.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign head_bit = shift_reg[WIDTH-1];
            assign shifted  = {shift_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign head_bit = shift_reg[0];
            assign shifted  = {1'b0, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    bit_down_counter #(.W(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (BIT_LOAD),
        .dec      (in_shift),
        .zero     (bit_zero)
    );

    bit_down_counter #(.W(CNT_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (last_bit && HAS_GAP),
        .load_val (GAP_LOAD),
        .dec      (in_gap),
        .zero     (gap_zero)
    );

    // State and shift register; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
        end
    end

    // Next-state and shift-register update.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                    shift_next = bus.load_data;
                end
            end
            ST_SHIFT: begin
                shift_next = shifted;
                if (bit_zero) begin
                    if (HAS_GAP) begin
                        state_next = ST_GAP;
                    end else if (accept) begin
                        state_next = ST_SHIFT;
                        shift_next = bus.load_data;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; the line is held low whenever no word bit is present.
    assign bus.load_ready = ready;
    assign bus.ser_valid  = in_shift;
    assign bus.ser_out    = in_shift && head_bit;
    assign bus.word_done  = last_bit;
    assign bus.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: three instances cover MSB-first,
// LSB-first and gapped configurations; expected bit streams are hand-written.
module tb_serial_word_feeder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   sel = 0;
    logic lv  = 1'b0;
    logic [7:0] ld = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    serial_word_feeder_if #(.WIDTH(8)) if_a ();
    serial_word_feeder_if #(.WIDTH(8)) if_b ();
    serial_word_feeder_if #(.WIDTH(8)) if_c ();

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );
    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut_c (
        .clk (clk), .rst (rst), .bus (if_c.slave)
    );

    always #5 clk = ~clk;

    assign if_a.load_valid = (sel == 0) && lv;
    assign if_b.load_valid = (sel == 1) && lv;
    assign if_c.load_valid = (sel == 2) && lv;
    assign if_a.load_data  = ld;
    assign if_b.load_data  = ld;
    assign if_c.load_data  = ld;

    logic s_ready, s_ser_out, s_ser_valid, s_word_done, s_busy;

    always_comb begin
        s_ready     = if_a.load_ready;
        s_ser_out   = if_a.ser_out;
        s_ser_valid = if_a.ser_valid;
        s_word_done = if_a.word_done;
        s_busy      = if_a.busy;
        case (sel)
            1: begin
                s_ready     = if_b.load_ready;
                s_ser_out   = if_b.ser_out;
                s_ser_valid = if_b.ser_valid;
                s_word_done = if_b.word_done;
                s_busy      = if_b.busy;
            end
            2: begin
                s_ready     = if_c.load_ready;
                s_ser_out   = if_c.ser_out;
                s_ser_valid = if_c.ser_valid;
                s_word_done = if_c.word_done;
                s_busy      = if_c.busy;
            end
            default: ;
        endcase
    end

    // Stand-in for the downstream detector on dut_a: counts runs reaching four 1s.
    logic [2:0] run_ones = 3'd0;
    int         det_hits = 0;
    always @(posedge clk) begin
        if (!rst) begin
            run_ones <= 3'd0;
        end else begin
            if (if_a.ser_out) begin
                run_ones <= (run_ones < 3'd4) ? run_ones + 3'd1 : 3'd4;
                if (run_ones == 3'd3) det_hits <= det_hits + 1;
            end else begin
                run_ones <= 3'd0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word on the selected instance and check its 8 bits; exp_seq[7] is the first bit.
    task automatic send_word(input logic [7:0] data, input logic [7:0] exp_seq, input string tag);
        lv = 1'b1;
        ld = data;
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        tick();
        lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(s_ser_valid), 32'd1);
            check($sformatf("%s_bit%0d", tag, i), 32'(s_ser_out), 32'(exp_seq[7-i]));
            check($sformatf("%s_done%0d", tag, i), 32'(s_word_done), 32'(i == 7));
            if (i < 7) tick();
        end
        tick();
        check({tag, "_idle_valid"}, 32'(s_ser_valid), 32'd0);
        check({tag, "_idle_out"}, 32'(s_ser_out), 32'd0);
        check({tag, "_idle_busy"}, 32'(s_busy), 32'd0);
        $display("word %02h sent (%s)", data, tag);
    endtask

    initial begin
        logic [7:0]  w2;
        logic [15:0] b2b;
        int          hits0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(s_ser_valid), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_done", 32'(s_word_done), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_out%0d", i), 32'(s_ser_out), 32'd0);
            check($sformatf("idle_valid%0d", i), 32'(s_ser_valid), 32'd0);
            check($sformatf("idle_ready%0d", i), 32'(s_ready), 32'd1);
            check($sformatf("idle_busy%0d", i), 32'(s_busy), 32'd0);
        end
        $display("reset/idle phase done");

        // MSB first, word 1101_1110, detector sees four 1s once
        sel = 0;
        hits0 = det_hits;
        send_word(8'hDE, 8'b1101_1110, "msb");
        check("det_hits", 32'(det_hits - hits0), 32'd1);

        // LSB first, A5 -> 1,0,1,0,0,1,0,1
        sel = 1;
        tick();
        send_word(8'hA5, 8'b1010_0101, "lsb");

        // Gap of 3 with load_valid held high: FF then 0F
        sel = 2;
        tick();
        lv = 1'b1;
        ld = 8'hFF;
        check("gap_ready0", 32'(s_ready), 32'd1);
        tick();
        ld = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("gap_w1_bit%0d", i), 32'(s_ser_out), 32'd1);
            check($sformatf("gap_w1_valid%0d", i), 32'(s_ser_valid), 32'd1);
            check($sformatf("gap_w1_done%0d", i), 32'(s_word_done), 32'(i == 7));
            check($sformatf("gap_w1_ready%0d", i), 32'(s_ready), 32'd0);
            if (i < 7) tick();
        end
        for (int g = 0; g < 3; g++) begin
            tick();
            check($sformatf("gap_valid%0d", g), 32'(s_ser_valid), 32'd0);
            check($sformatf("gap_out%0d", g), 32'(s_ser_out), 32'd0);
            check($sformatf("gap_ready%0d", g), 32'(s_ready), 32'd0);
            check($sformatf("gap_busy%0d", g), 32'(s_busy), 32'd1);
        end
        tick();
        check("gap_idle_ready", 32'(s_ready), 32'd1);
        check("gap_idle_busy", 32'(s_busy), 32'd0);
        check("gap_idle_valid", 32'(s_ser_valid), 32'd0);
        tick();
        lv = 1'b0;
        w2 = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("gap_w2_valid%0d", i), 32'(s_ser_valid), 32'd1);
            check($sformatf("gap_w2_bit%0d", i), 32'(s_ser_out), 32'(w2[7-i]));
            check($sformatf("gap_w2_done%0d", i), 32'(s_word_done), 32'(i == 7));
            if (i < 7) tick();
        end
        repeat (4) tick();
        check("gap_end_busy", 32'(s_busy), 32'd0);
        $display("gapped words FF, 0F sent");

        // Back to back, no gap: F0 then 0F
        sel = 0;
        tick();
        lv = 1'b1;
        ld = 8'hF0;
        b2b = 16'hF00F;
        check("b2b_ready0", 32'(s_ready), 32'd1);
        tick();
        ld = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) lv = 1'b0;
            check($sformatf("b2b_valid%0d", i), 32'(s_ser_valid), 32'd1);
            check($sformatf("b2b_bit%0d", i), 32'(s_ser_out), 32'(b2b[15-i]));
            check($sformatf("b2b_done%0d", i), 32'(s_word_done), 32'((i == 7) || (i == 15)));
            if (i == 7) check("b2b_ready_last", 32'(s_ready), 32'd1);
            if (i < 15) tick();
        end
        tick();
        check("b2b_end_valid", 32'(s_ser_valid), 32'd0);
        check("b2b_end_busy", 32'(s_busy), 32'd0);
        $display("back-to-back words F0, 0F sent");

        // Reset at bit 4 of FF
        tick();
        lv = 1'b1;
        ld = 8'hFF;
        tick();
        lv = 1'b0;
        repeat (3) tick();
        check("mid_valid_before", 32'(s_ser_valid), 32'd1);
        rst = 1'b0;
        lv  = 1'b1;
        ld  = 8'h81;
        tick();
        check("mid_rst_valid", 32'(s_ser_valid), 32'd0);
        check("mid_rst_out", 32'(s_ser_out), 32'd0);
        check("mid_rst_done", 32'(s_word_done), 32'd0);
        check("mid_rst_busy", 32'(s_busy), 32'd0);
        tick();
        check("rst_prio_busy", 32'(s_busy), 32'd0);
        check("rst_prio_done", 32'(s_word_done), 32'd0);
        rst = 1'b1;
        lv  = 1'b0;
        tick();
        check("rst_prio_valid", 32'(s_ser_valid), 32'd0);
        check("rst_prio_busy2", 32'(s_busy), 32'd0);
        check("rst_rel_ready", 32'(s_ready), 32'd1);
        $display("mid-word reset applied");
        send_word(8'h3C, 8'b0011_1100, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
